// File: rtl/fifo_rr_scheduler.sv
// Round-robin read scheduler for the per-port ingress FIFOs. It grants one FIFO
// at a time and forwards whole frames into a 2-entry valid/ready output queue.
module fifo_rr_scheduler #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS*(ADDR_WIDTH+1)-1:0] fifo_occu_out,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     read_data_out,
  output logic [NUM_PORTS-1:0]                read_enable,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [$clog2(NUM_PORTS)-1:0]        grant_id,
  output logic                                busy
);
  localparam int unsigned OCC_W = ADDR_WIDTH + 1;
  localparam int unsigned GNT_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t                state_q, state_d;
  logic [GNT_W-1:0]      ptr_q, ptr_d;
  logic [GNT_W-1:0]      grant_q, grant_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] q_mem [2];
  logic                  q_rd_q, q_wr_q;
  logic [1:0]            q_cnt_q;

  logic [OCC_W-1:0]      occ   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  nonempty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_slice
    assign occ[i]      = fifo_occu_out[i*OCC_W +: OCC_W];
    assign rdata[i]    = read_data_out[i*DATA_WIDTH +: DATA_WIDTH];
    assign nonempty[i] = (occ[i] != '0);
  end

  // First non-empty port at or after the round-robin pointer
  logic             pick_found;
  logic [GNT_W-1:0] pick_port;
  int unsigned      idx;
  always_comb begin
    pick_found = 1'b0;
    pick_port  = ptr_q;
    idx        = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = (32'(ptr_q) + k) % NUM_PORTS;
      if (!pick_found && nonempty[GNT_W'(idx)]) begin
        pick_found = 1'b1;
        pick_port  = GNT_W'(idx);
      end
    end
  end

  logic [OCC_W-1:0]      g_occ;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  pop, push, cap_eof, rd_ok;
  logic [1:0]            cnt_after_pop;

  assign g_occ         = occ[grant_q];
  assign g_data        = rdata[grant_q];
  assign pop           = out_valid & out_ready;
  assign push          = inflight_q;
  assign cap_eof       = inflight_q & g_data[DATA_WIDTH-1];
  assign cnt_after_pop = q_cnt_q - 2'(pop);

  // Eof lookahead keeps the next frame's first word in the FIFO
  assign rd_ok = (state_q == XFER)
              && (g_occ > OCC_W'(inflight_q))
              && ((cnt_after_pop + 2'(inflight_q)) < 2'd2)
              && !cap_eof;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    read_enable = '0;
    case (state_q)
      IDLE: if (|nonempty) state_d = ARB;
      ARB: begin
        if (pick_found) begin
          grant_d = pick_port;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (rd_ok) read_enable = NUM_PORTS'(1) << grant_q;
        if (cap_eof) begin
          ptr_d   = (grant_q == GNT_W'(NUM_PORTS - 1)) ? '0 : grant_q + GNT_W'(1);
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Output queue; captures the word returned by last cycle's read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      q_mem[0]   <= '0;
      q_mem[1]   <= '0;
      q_rd_q     <= 1'b0;
      q_wr_q     <= 1'b0;
      q_cnt_q    <= '0;
    end else begin
      inflight_q <= |read_enable;
      if (push) begin
        q_mem[q_wr_q] <= g_data;
        q_wr_q        <= ~q_wr_q;
      end
      if (pop) q_rd_q <= ~q_rd_q;
      q_cnt_q <= q_cnt_q + 2'(push) - 2'(pop);
    end
  end

  assign out_valid = (q_cnt_q != 2'd0);
  assign out_data  = q_mem[q_rd_q];
  assign grant_id  = grant_q;
  assign busy      = (state_q == XFER);

endmodule
